snes_joy_ports: RTL and testbench

Parametrised SNES controller-port emulator, successor to the single-pad joypad shift register in the ULX3S top level. It serves both SNES controller ports from up to five button vectors, including an optional 4-pad multitap on port 2. It adds per-button turbo (autofire) driven by a latch-event counter, and forces the standard-pad ID bits. It sits in the clk_sys domain between board button sources and the JOY_* pins of the SNES core.

---
 rtl/snes_joy_ports.sv | 152 +++++++++++++++
 tb/tb_snes_joy_ports.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/snes_joy_ports.sv
// SNES controller-port emulator: up to five pads on two ports, optional
// 4-pad multitap on port 2, per-button autofire and forced standard-pad ID.

// One 16-bit pad shift register: parallel load while latched, shift right
// on a port clock edge, zeros fill from the top so an exhausted pad reads 1s.
module snes_pad_sr (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        shift,
  input  logic [15:0] load_val,
  output logic        q0
);
  logic [15:0] sr;

  // load beats shift when the latch and a clock edge coincide
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   sr <= 16'hFFFF;
    else if (load)  sr <= load_val;
    else if (shift) sr <= {1'b0, sr[15:1]};
  end

  assign q0 = sr[0];
endmodule

module snes_joy_ports #(
  parameter int C_pads         = 2,
  parameter int C_multitap     = 0,
  parameter int C_turbo_frames = 4,
  parameter int C_sync_stages  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [16*C_pads-1:0]  pad_buttons,
  input  logic [16*C_pads-1:0]  turbo_en,
  input  logic                  joy_strb,
  input  logic                  joy1_clk,
  input  logic                  joy2_clk,
  input  logic                  joy2_p6,
  output logic [1:0]            joy1_di,
  output logic [1:0]            joy2_di,
  output logic                  turbo_phase
);
  localparam int NP = C_pads;

  logic [NP-1:0][15:0] btn_s;
  logic [NP-1:0][15:0] ten;
  logic [NP-1:0][15:0] load_val;
  logic [NP-1:0]       shift;
  logic [NP-1:0]       q;
  logic                strb_q, c1_q, c2_q;
  logic                rise1, rise2, strb_fall;
  logic [15:0]         tcnt;

  assign ten = turbo_en;

  // button synchroniser chain (pads are asynchronous to clk_sys)
  generate
    if (C_sync_stages == 0) begin : g_nosync
      assign btn_s = pad_buttons;
    end else begin : g_sync
      logic [C_sync_stages-1:0][16*NP-1:0] sync_q;
      // shift raw buttons through the synchroniser flops
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else begin
          sync_q[0] <= pad_buttons;
          for (int s = 1; s < C_sync_stages; s++) sync_q[s] <= sync_q[s-1];
        end
      end
      assign btn_s = sync_q[C_sync_stages-1];
    end
  endgenerate

  // previous-cycle copies of the core's strobe and port clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strb_q <= 1'b0;
      c1_q   <= 1'b0;
      c2_q   <= 1'b0;
    end else begin
      strb_q <= joy_strb;
      c1_q   <= joy1_clk;
      c2_q   <= joy2_clk;
    end
  end

  assign rise1     = joy1_clk & ~c1_q;
  assign rise2     = joy2_clk & ~c2_q;
  assign strb_fall = ~joy_strb & strb_q;

  // autofire phase flips every C_turbo_frames latch falls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt        <= '0;
      turbo_phase <= 1'b0;
    end else if (strb_fall) begin
      if (tcnt == 16'(C_turbo_frames - 1)) begin
        tcnt        <= '0;
        turbo_phase <= ~turbo_phase;
      end else begin
        tcnt <= tcnt + 16'd1;
      end
    end
  end

  // line-level load words and per-pad shift enables
  always_comb begin
    load_val = '0;
    shift    = '0;
    for (int p = 0; p < NP; p++) begin
      load_val[p][11:0]  = ~(btn_s[p][11:0] & (~ten[p][11:0] | {12{turbo_phase}}));
      load_val[p][15:12] = 4'hF;
      if (p == 0)               shift[p] = rise1;
      else if (C_multitap == 0) shift[p] = rise2;
      else if (p <= 2)          shift[p] = rise2 & joy2_p6;
      else                      shift[p] = rise2 & ~joy2_p6;
    end
  end

  genvar gp;
  generate
    for (gp = 0; gp < NP; gp++) begin : g_pad
      snes_pad_sr u_sr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (joy_strb),
        .shift    (shift[gp]),
        .load_val (load_val[gp]),
        .q0       (q[gp])
      );
    end
  endgenerate

  assign joy1_di = {1'b1, q[0]};

  // port 2 data mux: plain pad, or multitap pair selected by pin 6
  generate
    if (C_multitap != 0) begin : g_mt
      always_comb begin
        joy2_di = 2'b11;
        if (joy_strb)     joy2_di = {1'b0, q[1]};
        else if (joy2_p6) joy2_di = {q[2], q[1]};
        else              joy2_di = {q[4], q[3]};
      end
    end else if (NP >= 2) begin : g_p2
      assign joy2_di = {1'b1, q[1]};
    end else begin : g_nop2
      assign joy2_di = 2'b11;
    end
  endgenerate
endmodule

// File: tb/tb_snes_joy_ports.sv
// Bench for snes_joy_ports: a plain two-pad instance (turbo every 2 latches)
// and a multitap instance share the core-side strobe/clock lines.
module tb_snes_joy_ports;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        joy_strb = 1'b0, joy1_clk = 1'b0, joy2_clk = 1'b0, joy2_p6 = 1'b1;
  logic [31:0] pad_a = '0, ten_a = '0;
  logic [79:0] pad_m = '0, ten_m = '0;
  logic [1:0]  joy1_di_a, joy2_di_a, joy1_di_m, joy2_di_m;
  logic        tph_a, tph_m;

  int checks = 0, errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] got_log[0:31];
  int tcnt = 0;
  logic tphase = 1'b0;

  always #5 clk = ~clk;

  snes_joy_ports #(.C_pads(2), .C_multitap(0), .C_turbo_frames(2), .C_sync_stages(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .pad_buttons(pad_a), .turbo_en(ten_a),
    .joy_strb(joy_strb), .joy1_clk(joy1_clk), .joy2_clk(joy2_clk), .joy2_p6(joy2_p6),
    .joy1_di(joy1_di_a), .joy2_di(joy2_di_a), .turbo_phase(tph_a));

  snes_joy_ports #(.C_pads(5), .C_multitap(1), .C_turbo_frames(4), .C_sync_stages(2)) dut_m (
    .clk(clk), .reset_n(reset_n), .pad_buttons(pad_m), .turbo_en(ten_m),
    .joy_strb(joy_strb), .joy1_clk(joy1_clk), .joy2_clk(joy2_clk), .joy2_p6(joy2_p6),
    .joy1_di(joy1_di_m), .joy2_di(joy2_di_m), .turbo_phase(tph_m));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // line level a pad presents: 0 = pressed, ID nibble forced high
  function automatic logic [15:0] line_word(input logic [15:0] p, input logic [15:0] t, input logic ph);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = (i >= 12) ? 1'b1 : !(p[i] && (!t[i] || ph));
    return v;
  endfunction

  function automatic logic bitk(input logic [15:0] w, input int k);
    return (k < 16) ? w[k] : 1'b0;
  endfunction

  // queue n expected samples; hi_fixed holds data line 1 at 1
  task automatic push_exp(input logic hi_fixed, input logic [15:0] hi, input logic [15:0] lo, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({hi_fixed ? 1'b1 : bitk(hi, k), bitk(lo, k)});
  endtask

  function automatic void note_fall();
    if (tcnt == 1) begin tcnt = 0; tphase = ~tphase; end
    else tcnt++;
  endfunction

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    joy_strb = 1'b1;
    @(posedge clk); #1;
    joy_strb = 1'b0;
    @(posedge clk); #1;
    note_fall();
  endtask

  // sample, compare against scoreboard, then pulse the port clock
  task automatic read_seq(input string tag, input int which, input int n);
    logic [1:0] got, exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = (which == 0) ? joy1_di_a : (which == 1) ? joy2_di_a : joy2_di_m;
      got_log[i] = got;
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
      else begin
        exp = exp_q.pop_front();
        chk($sformatf("%s[%0d]", tag, i), got, exp);
      end
      @(posedge clk); #1;
      if (which == 0) joy1_clk = 1'b1; else joy2_clk = 1'b1;
      @(posedge clk); #1;
      joy1_clk = 1'b0;
      joy2_clk = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] turbo_tbl;
    logic [15:0] l1, l2, l3, l4;
    turbo_tbl = 8'b0011_0011; // frame f expects bit f (1,1,0,0,1,1,0,0)

    repeat (2) @(posedge clk);
    #1;
    chk("rst_joy1_a", joy1_di_a, 2'b11);
    chk("rst_joy2_a", joy2_di_a, 2'b11);
    chk("rst_joy2_m", joy2_di_m, 2'b11);
    chk("rst_phase",  tph_a, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // autofire on A
    pad_a[15:0] = 16'h0100;
    ten_a[15:0] = 16'h0100;
    settle();
    for (int f = 0; f < 8; f++) begin
      push_exp(1'b1, 16'h0, line_word(16'h0100, 16'h0100, tphase), 20);
      strobe();
      read_seq($sformatf("turbo_f%0d", f), 0, 20);
      chk($sformatf("turbo_b8_f%0d", f), got_log[8][0], turbo_tbl[f]);
      chk($sformatf("turbo_phase_f%0d", f), tph_a, tphase);
    end
    ten_a = '0;

    // single pad B+Right, overrun reads 0
    pad_a[15:0] = 16'h0081;
    settle();
    push_exp(1'b1, 16'h0, line_word(16'h0081, 16'h0, tphase), 20);
    strobe();
    read_seq("single", 0, 20);

    // ID nibble forced with everything pressed
    pad_a[15:0] = 16'hFFFF;
    settle();
    push_exp(1'b1, 16'h0, 16'h0FFF & 16'h0000 | 16'hF000, 20);
    strobe();
    read_seq("idforce", 0, 20);

    // port 2 without multitap
    pad_a[31:16] = 16'h0F00;
    settle();
    push_exp(1'b1, 16'h0, line_word(16'h0F00, 16'h0, tphase), 20);
    strobe();
    read_seq("port2", 1, 20);

    // clock edge coinciding with the latch: load wins
    pad_a[15:0] = 16'h0081;
    settle();
    push_exp(1'b1, 16'h0, line_word(16'h0081, 16'h0, tphase), 3);
    strobe();
    read_seq("simul_pre", 0, 3);
    joy_strb = 1'b1;
    joy1_clk = 1'b1;
    @(posedge clk); #1;
    joy_strb = 1'b0;
    joy1_clk = 1'b0;
    @(posedge clk); #1;
    note_fall();
    push_exp(1'b1, 16'h0, line_word(16'h0081, 16'h0, tphase), 20);
    read_seq("simul", 0, 20);

    // reset in the middle of a read
    push_exp(1'b1, 16'h0, line_word(16'h0081, 16'h0, tphase), 5);
    strobe();
    read_seq("midrst_pre", 0, 5);
    reset_n = 1'b0;
    #1;
    chk("midrst_joy1_a", joy1_di_a, 2'b11);
    chk("midrst_joy2_a", joy2_di_a, 2'b11);
    chk("midrst_joy2_m", joy2_di_m, 2'b11);
    @(posedge clk); #1;
    chk("midrst_phase", tph_a, 1'b0);
    reset_n = 1'b1;
    tcnt = 0;
    tphase = 1'b0;
    @(posedge clk); #1;
    push_exp(1'b1, 16'h0, 16'hFFFF, 20);
    read_seq("midrst_post", 0, 20);

    // multitap: pads 1..4 press B, Y, Select, Start
    pad_m = {16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0000};
    l1 = line_word(16'h0001, 16'h0, 1'b0);
    l2 = line_word(16'h0002, 16'h0, 1'b0);
    l3 = line_word(16'h0004, 16'h0, 1'b0);
    l4 = line_word(16'h0008, 16'h0, 1'b0);
    joy2_p6 = 1'b1;
    settle();
    joy_strb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mt_strb_sig", joy2_di_m, 2'b00);
    @(posedge clk); #1;
    joy_strb = 1'b0;
    @(posedge clk); #1;
    note_fall();
    push_exp(1'b0, l2, l1, 20);
    read_seq("mt_p6hi", 2, 20);
    joy2_p6 = 1'b0;
    push_exp(1'b0, l4, l3, 20);
    read_seq("mt_p6lo", 2, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
